// File: rtl/osc_pkg.sv
// Shared sizing, state encoding and pointer helper for the oscilloscope capture controller.
package osc_pkg;

    localparam int ADDR_W          = 15;
    localparam int DEPTH_DEFAULT   = 10000;
    localparam int PRETRIG_DEFAULT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] ptr,
                                                   input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] nxt;
        if (ptr == last) begin
            nxt = {ADDR_W{1'b0}};
        end else begin
            nxt = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/capture_ctrl_trig_detect.sv
// Edge trigger: remembers the last accepted sample and flags a threshold crossing
// between it and the sample currently being accepted.
module trig_detect (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       accept_i,
    input  logic [7:0] data_i,
    input  logic [7:0] level_i,
    input  logic       rising_i,
    output logic       trig_o
);

    logic [7:0] prev_q;
    logic [7:0] prev_d;

    // Crossing compare against the previous accepted sample; prev follows accepted samples only.
    always_comb begin
        prev_d = prev_q;
        if (accept_i) begin
            prev_d = data_i;
        end else begin
            prev_d = prev_q;
        end
        if (rising_i) begin
            trig_o = (prev_q < level_i) && (data_i >= level_i);
        end else begin
            trig_o = (prev_q >= level_i) && (data_i < level_i);
        end
    end

    // Previous-sample register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q <= 8'd0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture sequencer writing ADC bytes into a circular buffer.
// Define OSC_TRIGGER_EN for level/edge trigger detection; otherwise the first armed sample triggers.
module capture_ctrl
    import osc_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int PRETRIG = PRETRIG_DEFAULT
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        sample_data,
    input  logic              arm,
    input  logic [7:0]        trig_level,
    input  logic              trig_rising,
    input  logic              pi_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              pi_signal_flag,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LEN   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] POST_LEN  = ADDR_W'(DEPTH - PRETRIG - 1);
    localparam logic [ADDR_W-1:0] ZERO      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              accept_s;
    logic              trig_hit_s;
    logic [ADDR_W-1:0] cnt_inc_s;

    // Dropping arm cancels the sample in flight, so acceptance needs arm as well.
    assign accept_s  = sample_valid && arm &&
                       ((state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST));
    assign cnt_inc_s = cnt_q + ONE;

`ifdef OSC_TRIGGER_EN
    trig_detect u_trig_detect (
        .clk_i    (osc_clk),
        .reset_i  (reset),
        .accept_i (accept_s),
        .data_i   (sample_data),
        .level_i  (trig_level),
        .rising_i (trig_rising),
        .trig_o   (trig_hit_s)
    );
`else
    logic unused_s;
    assign unused_s   = ^{trig_level, trig_rising};
    assign trig_hit_s = 1'b1;
`endif

    // Next-state and write-port logic; a sample on a transition edge counts in the state being left.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        flag_d      = flag_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_PRE;
                    ptr_d   = ZERO;
                    cnt_d   = ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == PRE_LEN) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_PRE;
                    end
                end else begin
                    state_d = ST_PRE;
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (accept_s && trig_hit_s) begin
                    state_d     = ST_POST;
                    cnt_d       = ZERO;
                    trig_addr_d = ptr_q;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_POST: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == POST_LEN) begin
                        state_d = ST_DONE;
                        flag_d  = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_DONE: begin
                if (pi_ack) begin
                    state_d = ST_IDLE;
                    flag_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flag_d  = 1'b0;
            end
        endcase
        if (accept_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sample_data;
            ptr_d     = ptr_next(ptr_q, LAST_ADDR);
        end else begin
            wr_en_d = 1'b0;
        end
        busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
    end

    // State and registered outputs.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ZERO;
            cnt_q       <= ZERO;
            trig_addr_q <= ZERO;
            wr_addr_q   <= ZERO;
            wr_data_q   <= 8'd0;
            wr_en_q     <= 1'b0;
            flag_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            flag_q      <= flag_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign trig_addr      = trig_addr_q;
    assign pi_signal_flag = flag_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl (DEPTH=16, PRETRIG=4): directed scenarios plus randomized traffic
// compared every cycle against a counting model of the capture sequence.
module tb_capture_ctrl;

    localparam int DEPTH    = 16;
    localparam int PRETRIG  = 4;
    localparam int POST_LEN = DEPTH - PRETRIG - 1;
`ifdef OSC_TRIGGER_EN
    localparam int FALL_EXP  = 8;
    localparam int WRAP_EXP  = 1;
    localparam int WFLAG_EXP = 0;
`else
    localparam int FALL_EXP  = 4;
    localparam int WRAP_EXP  = 0;
    localparam int WFLAG_EXP = 1;
`endif

    logic        osc_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = 8'd0;
    logic        arm = 1'b0;
    logic [7:0]  trig_level = 8'd0;
    logic        trig_rising = 1'b1;
    logic        pi_ack = 1'b0;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [14:0] trig_addr;
    logic        pi_signal_flag;
    logic        busy;

    always #5 osc_clk = ~osc_clk;

    capture_ctrl #(.DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
        .osc_clk        (osc_clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .arm            (arm),
        .trig_level     (trig_level),
        .trig_rising    (trig_rising),
        .pi_ack         (pi_ack),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .trig_addr      (trig_addr),
        .pi_signal_flag (pi_signal_flag),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: a capture is "active" until it is dropped or completes; progress is kept as
    // counts of pre-trigger and post-trigger samples written.
    bit m_active = 0, m_done = 0, m_trig = 0, m_rst_now = 0;
    int m_pre = 0, m_post = 0, m_ptr = 0, m_prev = 0;
    int e_wr_en = 0, e_wr_addr = 0, e_wr_data = 0, e_trig = 0, e_flag = 0, e_busy = 0;

    int obs_wr_cnt = 0, obs_last_addr = -1;
    bit obs_wrap = 0, obs_flag_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_trigger(input int p, input int s);
        bit hit;
        hit = trig_rising ? ((p < int'(trig_level)) && (s >= int'(trig_level)))
                          : ((p >= int'(trig_level)) && (s < int'(trig_level)));
`ifndef OSC_TRIGGER_EN
        hit = 1'b1;
`endif
        return hit;
    endfunction

    task automatic model_update();
        e_wr_en   = 0;
        m_rst_now = 0;
        if (reset) begin
            m_rst_now = 1;
            m_active = 0; m_done = 0; m_trig = 0; m_ptr = 0; m_prev = 0;
            e_wr_addr = 0; e_wr_data = 0; e_trig = 0; e_flag = 0;
        end else if (m_done) begin
            if (pi_ack) begin
                m_done = 0;
                e_flag = 0;
            end
        end else if (!m_active) begin
            if (arm) begin
                m_active = 1; m_pre = 0; m_post = 0; m_trig = 0; m_ptr = 0;
            end
        end else if (!arm) begin
            m_active = 0;
        end else if (sample_valid) begin
            e_wr_en   = 1;
            e_wr_addr = m_ptr;
            e_wr_data = int'(sample_data);
            if (m_pre < PRETRIG) begin
                m_pre++;
            end else if (!m_trig) begin
                if (is_trigger(m_prev, int'(sample_data))) begin
                    m_trig = 1;
                    e_trig = m_ptr;
                end
            end else begin
                m_post++;
                if (m_post == POST_LEN) begin
                    m_active = 0;
                    m_done   = 1;
                    e_flag   = 1;
                end
            end
            m_prev = int'(sample_data);
            m_ptr  = (m_ptr + 1) % DEPTH;
        end
        e_busy = m_active ? 1 : 0;
    endtask

    task automatic compare();
        chk("wr_en", int'(wr_en), e_wr_en);
        if ((e_wr_en != 0) || m_rst_now) begin
            chk("wr_addr", int'(wr_addr), e_wr_addr);
            chk("wr_data", int'(wr_data), e_wr_data);
        end
        chk("trig_addr", int'(trig_addr), e_trig);
        chk("pi_signal_flag", int'(pi_signal_flag), e_flag);
        chk("busy", int'(busy), e_busy);
        if (wr_en) begin
            obs_wr_cnt++;
            if ((wr_addr == 15'd0) && (obs_last_addr == DEPTH - 1)) obs_wrap = 1;
            obs_last_addr = int'(wr_addr);
        end
        if (pi_signal_flag) obs_flag_seen = 1;
    endtask

    task automatic step();
        @(posedge osc_clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic feed(input int d);
        sample_valid = 1'b1;
        sample_data  = 8'(d);
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        int fall_seq[9] = '{100, 100, 100, 100, 100, 100, 120, 110, 90};

        // Reset state
        step();
        step();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flag", int'(pi_signal_flag), 0);
        chk("rst_trig_addr", int'(trig_addr), 0);

        // Rising ramp through 128; starting at 124 puts 128 right after pre-trigger
        reset = 1'b0; arm = 1'b1; trig_level = 8'd128; trig_rising = 1'b1;
        obs_wr_cnt = 0; obs_flag_seen = 0;
        step();
        for (int i = 0; i < 40 && !pi_signal_flag; i++) feed((124 + i) % 256);
        chk("ramp_flag", int'(pi_signal_flag), 1);
        chk("ramp_trig_addr", int'(trig_addr), 4);
        chk("ramp_writes", obs_wr_cnt, 16);
        feed(200);
        feed(201);
        chk("done_ignores_samples", obs_wr_cnt, 16);

        // pi_ack with arm held: IDLE, then PRE one cycle later
        pi_ack = 1'b1; step(); pi_ack = 1'b0;
        chk("ack_busy_idle", int'(busy), 0);
        chk("ack_flag_clear", int'(pi_signal_flag), 0);
        step();
        chk("ack_repre_busy", int'(busy), 1);
        feed(7);
        chk("repre_first_addr", int'(wr_addr), 0);
        arm = 1'b0; step();
        chk("disarm_busy", int'(busy), 0);
        pi_ack = 1'b1; step(); pi_ack = 1'b0;
        chk("idle_ack_busy", int'(busy), 0);
        chk("idle_ack_flag", int'(pi_signal_flag), 0);
        step();
        chk("idle_ack_stays", int'(busy), 0);

        // Falling edge at 100: flat 100s and 120->110 must not trigger, 110->90 must
        arm = 1'b1; trig_level = 8'd100; trig_rising = 1'b0;
        step();
        foreach (fall_seq[i]) feed(fall_seq[i]);
        chk("fall_trig_addr", int'(trig_addr), FALL_EXP);

        // Drop arm mid-capture with a sample arriving: nothing written, flag stays low
        arm = 1'b0; sample_valid = 1'b1; sample_data = 8'd77;
        step();
        sample_valid = 1'b0;
        chk("drop_busy", int'(busy), 0);
        chk("drop_wr_en", int'(wr_en), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_no_write", int'(wr_en), 0);
            chk("drop_flag", int'(pi_signal_flag), 0);
            chk("drop_trig_hold", int'(trig_addr), FALL_EXP);
        end

        // Long armed period without a crossing
        arm = 1'b1; trig_level = 8'd200; trig_rising = 1'b1;
        obs_wrap = 0; obs_flag_seen = 0; obs_last_addr = -1;
        step();
        for (int i = 0; i < 40; i++) feed(50);
        chk("armed_wrap", int'(obs_wrap), WRAP_EXP);
        chk("armed_flag_seen", int'(obs_flag_seen), WFLAG_EXP);
        arm = 1'b0; step();
        pi_ack = 1'b1; step(); pi_ack = 1'b0;
        step();
        chk("wrap_exit_busy", int'(busy), 0);

        // Reset in POST with a sample arriving
        arm = 1'b1; trig_level = 8'd128; trig_rising = 1'b1;
        step();
        for (int i = 0; i < 8; i++) feed(124 + i);
        chk("post_busy", int'(busy), 1);
        reset = 1'b1; sample_valid = 1'b1; sample_data = 8'd99;
        step();
        reset = 1'b0; sample_valid = 1'b0;
        chk("rst_post_wr_en", int'(wr_en), 0);
        chk("rst_post_wr_addr", int'(wr_addr), 0);
        chk("rst_post_wr_data", int'(wr_data), 0);
        chk("rst_post_trig", int'(trig_addr), 0);
        chk("rst_post_flag", int'(pi_signal_flag), 0);
        chk("rst_post_busy", int'(busy), 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 499) == 0);
            arm          = ($urandom_range(0, 99) < 98);
            pi_ack       = ($urandom_range(0, 7) == 0);
            sample_valid = 1'($urandom_range(0, 1));
            sample_data  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) begin
                trig_level  = 8'($urandom_range(0, 255));
                trig_rising = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
